sauria_obi_width_adapter: RTL
=============================

# sauria_obi_width_adapter

Upstream neighbour of the SAURIA core wrapper's SRAM port: converts the 32-bit OBI requests issued by the host into the 128-bit OBI requests that the wrapper's OBI-to-AXI bridge expects. A small in-order FIFO records the lane of every granted request. Each wide response is returned to the host on the correct narrow lane.

## Interface
Parameters:
- NARROW_DW, 32, host-side OBI data width (bits).
- WIDE_DW, 128, wrapper-side OBI data width; integer multiple of NARROW_DW.
- ADDR_WIDTH, 32, OBI address width on both sides.
- MAX_OUTSTANDING, 4, depth of the lane FIFO (power of two, ≥2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- slv_req_i  in  1  host request valid.
- slv_gnt_o  out  1  host grant.
- slv_addr_i  in  ADDR_WIDTH  host byte address.
- slv_we_i  in  1  write enable.
- slv_be_i  in  NARROW_DW/8  byte enables.
- slv_wdata_i  in  NARROW_DW  write data.
- slv_rvalid_o  out  1  response valid.
- slv_rdata_o  out  NARROW_DW  response data.
- mst_req_o  out  1  wide request valid.
- mst_gnt_i  in  1  wide grant.
- mst_addr_o  out  ADDR_WIDTH  wide-aligned address.
- mst_we_o  out  1  write enable.
- mst_be_o  out  WIDE_DW/8  byte enables.
- mst_wdata_o  out  WIDE_DW  write data.
- mst_rvalid_i  in  1  wide response valid.
- mst_rdata_i  in  WIDE_DW  wide response data.
- err_o  out  1  sticky protocol error: response with no outstanding request.

## Operation
- Definitions:
  - NB = NARROW_DW/8 and WB = WIDE_DW/8.
  - LANES = WB/NB.
  - lane = slv_addr_i[log2(WB)-1 : log2(NB)].
- Request path (combinational):
  - mst_req_o = slv_req_i & ~full.
  - slv_gnt_o = mst_gnt_i & ~full.
  - mst_addr_o = slv_addr_i with the low log2(WB) bits forced to 0.
  - mst_we_o = slv_we_i.
  - mst_wdata_o = slv_wdata_i replicated LANES times.
  - mst_be_o = slv_be_i placed at bit lane*NB, all other bits 0. Reads carry the same byte-enable pattern.
- Accept: a request is accepted when slv_req_i & slv_gnt_o. On accept, push lane into the FIFO.
- Response path:
  - slv_rvalid_o = mst_rvalid_i.
  - slv_rdata_o = mst_rdata_i[head_lane*NARROW_DW +: NARROW_DW].
  - Each response pops the FIFO.
- Empty FIFO with mst_rvalid_i high:
  - slv_rvalid_o is still driven.
  - slv_rdata_o uses lane 0.
  - No pop occurs and the count stays at 0.
  - err_o sets and holds until reset.
- FIFO:
  - Write and read pointers are log2(MAX_OUTSTANDING) bits and wrap modulo depth.
  - The occupancy counter is log2(MAX_OUTSTANDING)+1 bits.
  - full = (count == MAX_OUTSTANDING); empty = (count == 0).
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- When full, the grant is blocked even if a pop occurs in the same cycle. This avoids a combinational path from mst_rvalid_i to slv_gnt_o. Full throughput is therefore MAX_OUTSTANDING-1 in flight at steady state with back-to-back responses.
- Ordering: responses are assumed in order, as OBI guarantees. There is no ID tracking.

## Timing
- Reset values: pointers 0, count 0, err_o 0, FIFO contents 0. The combinational outputs follow their inputs; with all inputs at 0 they are all 0.
- Request and response paths have zero added latency. The only state is the FIFO and err_o, both updated on the rising clock edge.
- A push is visible to full/empty on the next cycle. A lane pushed in cycle N can be popped in cycle N+1 at the earliest.
- Reset during operation clears the FIFO immediately (asynchronous). Responses to pre-reset requests that arrive after reset set err_o.
- Handshake:
  - slv_req_i may be held across cycles without a grant. The adapter never deasserts slv_gnt_o because of slv_req_i.
  - Address, we, be and wdata must be stable while request is high and grant is low (host obligation; checked by assertion).

## Structure
- Shared package sauria_obi_pkg holds:
  - the NB/WB/LANES derivation functions;
  - the lane-index typedef;
  - the lane-placement function for byte enables.
- One sub-module, sauria_lane_fifo: a parameterised in-order FIFO with push, pop, full, empty, count and head. It is reusable for the AXI-Lite config path later.
- Top level adds the request/response muxing and err_o.

## Test plan
- Single write: addr 0x1008, be 0xF, wdata 0xDEADBEEF -> mst_addr_o 0x1000, mst_be_o 0x0F00, mst_wdata_o 0xDEADBEEF ×4, FIFO count 1 then 0 after rvalid.
- Read on lane 3: addr 0x200C; respond with rdata 0x44444444_33333333_22222222_11111111 -> slv_rdata_o 0x44444444 on the same cycle as rvalid.
- Four back-to-back reads to lanes 0,1,2,3, responses withheld -> fifth request sees slv_gnt_o=0. Then four responses return 0x11…,0x22…,0x33…,0x44… in order.
- Simultaneous push/pop with count 2 -> count stays 2, both pointers advance. Wrap-around verified over 10 transactions.
- Spurious mst_rvalid_i with empty FIFO -> err_o=1 next cycle and held, count stays 0.
- rst_ni pulsed low with 3 outstanding -> count 0, err_o 0 during reset. A late response after release sets err_o.

Source files
------------

// File: rtl/sauria_obi_pkg.sv
// Shared helpers for the SAURIA OBI width adapter: byte/lane derivations
// and byte-enable lane placement.
package sauria_obi_pkg;

  // Widest byte-enable vector the placement helper supports (1024-bit bus).
  localparam int MAX_BE_W  = 128;
  localparam int DEF_LANES = 4;

  // Lane index for the default 32-to-128 configuration.
  typedef logic [$clog2(DEF_LANES)-1:0] lane_t;

  function automatic int nb_of(input int narrow_dw);
    return narrow_dw / 8;
  endfunction

  function automatic int wb_of(input int wide_dw);
    return wide_dw / 8;
  endfunction

  function automatic int lanes_of(input int narrow_dw, input int wide_dw);
    return wide_dw / narrow_dw;
  endfunction

  // Shift a narrow byte-enable vector up to its lane inside the wide vector.
  function automatic logic [MAX_BE_W-1:0] place_be(input logic [MAX_BE_W-1:0] be,
                                                   input int lane, input int nbytes);
    return be << (lane * nbytes);
  endfunction

endpackage

// File: rtl/sauria_lane_fifo.sv
// In-order FIFO with occupancy counter; pushes into a full FIFO and pops
// from an empty one are ignored.
module sauria_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 2,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW:0]   count_o,
  output logic [DW-1:0] head_o
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][DW-1:0] r_mem;
  logic [PW-1:0]            r_wptr;
  logic [PW-1:0]            r_rptr;
  logic [PW:0]              r_count;
  logic                     w_push;
  logic                     w_pop;

  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // Storage, pointers (wrapping modulo DEPTH) and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sauria_obi_width_adapter.sv
// Narrow (host) to wide (wrapper) OBI adapter. Requests are widened with
// zero latency; the lane of each granted request is queued so the matching
// in-order response can be steered back onto the narrow data bus.
module sauria_obi_width_adapter
  import sauria_obi_pkg::*;
#(
  parameter int NARROW_DW       = 32,
  parameter int WIDE_DW         = 128,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   slv_req_i,
  output logic                   slv_gnt_o,
  input  logic [ADDR_WIDTH-1:0]  slv_addr_i,
  input  logic                   slv_we_i,
  input  logic [NARROW_DW/8-1:0] slv_be_i,
  input  logic [NARROW_DW-1:0]   slv_wdata_i,
  output logic                   slv_rvalid_o,
  output logic [NARROW_DW-1:0]   slv_rdata_o,
  output logic                   mst_req_o,
  input  logic                   mst_gnt_i,
  output logic [ADDR_WIDTH-1:0]  mst_addr_o,
  output logic                   mst_we_o,
  output logic [WIDE_DW/8-1:0]   mst_be_o,
  output logic [WIDE_DW-1:0]     mst_wdata_o,
  input  logic                   mst_rvalid_i,
  input  logic [WIDE_DW-1:0]     mst_rdata_i,
  output logic                   err_o
);

  localparam int NB    = nb_of(NARROW_DW);
  localparam int WB    = wb_of(WIDE_DW);
  localparam int LANES = lanes_of(NARROW_DW, WIDE_DW);
  localparam int NBL   = $clog2(NB);
  localparam int WBL   = $clog2(WB);
  localparam int LW    = $clog2(LANES);
  localparam int PW    = $clog2(MAX_OUTSTANDING);

  logic [LW-1:0] w_lane;
  logic [LW-1:0] w_head;
  logic [LW-1:0] w_rd_lane;
  logic [PW:0]   w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_unused;
  logic          r_err;

  assign w_lane   = slv_addr_i[WBL-1:NBL];
  assign w_unused = ^{slv_addr_i[NBL-1:0], w_count};

  // Grant is gated only by the registered full flag, never by this cycle's
  // pop, so there is no combinational path from mst_rvalid_i to slv_gnt_o.
  assign mst_req_o   = slv_req_i & ~w_full;
  assign slv_gnt_o   = mst_gnt_i & ~w_full;
  assign w_push      = slv_req_i & slv_gnt_o;
  assign mst_addr_o  = {slv_addr_i[ADDR_WIDTH-1:WBL], {WBL{1'b0}}};
  assign mst_we_o    = slv_we_i;
  assign mst_wdata_o = {LANES{slv_wdata_i}};
  assign mst_be_o    = WB'(place_be(MAX_BE_W'(slv_be_i), int'(w_lane), NB));

  // A response with nothing outstanding is still forwarded, read from lane 0.
  assign w_pop        = mst_rvalid_i & ~w_empty;
  assign w_rd_lane    = w_empty ? '0 : w_head;
  assign slv_rvalid_o = mst_rvalid_i;
  assign slv_rdata_o  = mst_rdata_i[w_rd_lane*NARROW_DW +: NARROW_DW];
  assign err_o        = r_err;

  sauria_lane_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .DW    (LW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_lane),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count),
    .head_o  (w_head)
  );

  // Sticky error on a response that matches no outstanding request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err <= 1'b0;
    else if (mst_rvalid_i && w_empty) r_err <= 1'b1;
  end

`ifndef SYNTHESIS
  // Host must keep the request payload stable while waiting for a grant.
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slv_req_i && !slv_gnt_o) |=> (!slv_req_i || ($stable(slv_addr_i) &&
      $stable(slv_we_i) && $stable(slv_be_i) && $stable(slv_wdata_i))));
`endif

endmodule
